// File: rtl/w0rm_mem_arbiter_if.sv
// Bus bundle for the two-requester RAM arbiter: both requester ports plus the RAM port.
interface w0rm_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]     p0_addr_i, p1_addr_i;
  logic [DATA_WIDTH-1:0]     p0_data_i, p1_data_i;
  logic                      p0_read_i, p1_read_i;
  logic                      p0_write_i, p1_write_i;
  logic                      p0_valid_i, p1_valid_i;
  logic                      p0_busy_o, p1_busy_o;
  logic [DATA_WIDTH-1:0]     p0_data_o, p1_data_o;
  logic                      p0_valid_o, p1_valid_o;
  logic                      p0_overrun_o, p1_overrun_o;
  logic                      ram_en_o;
  logic                      ram_we_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0]     ram_din_o;
  logic [DATA_WIDTH-1:0]     ram_dout_i;

  // Arbiter side.
  modport slave (
    input  p0_addr_i, p1_addr_i, p0_data_i, p1_data_i, p0_read_i, p1_read_i,
    input  p0_write_i, p1_write_i, p0_valid_i, p1_valid_i, ram_dout_i,
    output p0_busy_o, p1_busy_o, p0_data_o, p1_data_o, p0_valid_o, p1_valid_o,
    output p0_overrun_o, p1_overrun_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o
  );

  // Requesters and RAM side.
  modport master (
    output p0_addr_i, p1_addr_i, p0_data_i, p1_data_i, p0_read_i, p1_read_i,
    output p0_write_i, p1_write_i, p0_valid_i, p1_valid_i, ram_dout_i,
    input  p0_busy_o, p1_busy_o, p0_data_o, p1_data_o, p0_valid_o, p1_valid_o,
    input  p0_overrun_o, p1_overrun_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o
  );
endinterface

// File: rtl/w0rm_mem_arbiter.sv
// Two-requester round-robin arbiter onto one single-port RAM. Each requester owns a
// one-deep pending slot; one slot is granted per cycle and its completion is signalled
// one cycle later, alongside the RAM read data.
module w0rm_mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 10
) (
  input logic                core_clk,
  input logic                reset,
  w0rm_mem_arbiter_if.slave  bus
);

  logic [1:0]                req_valid, req_read, req_write;
  logic [ADDR_WIDTH-1:0]     req_addr [2];
  logic [DATA_WIDTH-1:0]     req_data [2];

  logic [1:0]                full_q, full_d, we_q, we_d, overrun_q, overrun_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q [2];
  logic [RAM_ADDR_WIDTH-1:0] addr_d [2];
  logic [DATA_WIDTH-1:0]     data_q [2];
  logic [DATA_WIDTH-1:0]     data_d [2];
  logic                      last_q, last_d;
  logic                      tag_valid_q, tag_valid_d;
  logic                      tag_owner_q, tag_owner_d;
  logic                      tag_read_q, tag_read_d;

  logic                      gnt_valid, gnt_idx;
  logic [1:0]                gnt_oh, busy;
  logic                      unused_addr;

  assign req_valid   = {bus.p1_valid_i, bus.p0_valid_i};
  assign req_read    = {bus.p1_read_i, bus.p0_read_i};
  assign req_write   = {bus.p1_write_i, bus.p0_write_i};
  assign req_addr[0] = bus.p0_addr_i;
  assign req_addr[1] = bus.p1_addr_i;
  assign req_data[0] = bus.p0_data_i;
  assign req_data[1] = bus.p1_data_i;

  // Only the word-address field is used; the remaining address bits wrap away.
  assign unused_addr = ^{bus.p0_addr_i, bus.p1_addr_i};

  // Grant: a lone full slot always wins; on a tie the slot not granted last wins.
  always_comb begin
    gnt_valid = |full_q;
    gnt_idx   = (&full_q) ? ~last_q : full_q[1];
    gnt_oh    = gnt_valid ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    busy      = full_q & ~gnt_oh;
  end

  // Slot refill/clear, overrun flags, last-grant pointer and completion tag.
  always_comb begin
    full_d    = full_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && (req_read[i] || req_write[i])) begin
        if (!busy[i]) begin
          // A slot granted this cycle may be refilled in the same cycle.
          full_d[i] = 1'b1;
          we_d[i]   = req_write[i];
          addr_d[i] = req_addr[i][RAM_ADDR_WIDTH+1:2];
          data_d[i] = req_data[i];
        end else begin
          overrun_d[i] = 1'b1;
        end
      end else if (gnt_oh[i]) begin
        full_d[i] = 1'b0;
      end
    end
    last_d      = gnt_valid ? gnt_idx : last_q;
    tag_valid_d = gnt_valid;
    tag_owner_d = gnt_idx;
    tag_read_d  = gnt_valid & ~we_q[gnt_idx];
  end

  // State registers; reset points the last grant at p1 so p0 wins the first tie.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      full_q      <= '0;
      we_q        <= '0;
      addr_q[0]   <= '0;
      addr_q[1]   <= '0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      overrun_q   <= '0;
      last_q      <= 1'b1;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
      tag_read_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      last_q      <= last_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      tag_read_q  <= tag_read_d;
    end
  end

  // RAM drive straight from the granted slot; all zero when idle.
  always_comb begin
    bus.ram_en_o   = gnt_valid;
    bus.ram_we_o   = 1'b0;
    bus.ram_addr_o = '0;
    bus.ram_din_o  = '0;
    if (gnt_valid) begin
      bus.ram_we_o   = we_q[gnt_idx];
      bus.ram_addr_o = addr_q[gnt_idx];
      bus.ram_din_o  = data_q[gnt_idx];
    end
  end

  // Requester-facing outputs: busy, completion strobes, read data and overrun flags.
  always_comb begin
    bus.p0_busy_o    = busy[0];
    bus.p1_busy_o    = busy[1];
    bus.p0_valid_o   = tag_valid_q & ~tag_owner_q;
    bus.p1_valid_o   = tag_valid_q & tag_owner_q;
    bus.p0_data_o    = (tag_valid_q && !tag_owner_q && tag_read_q) ? bus.ram_dout_i : '0;
    bus.p1_data_o    = (tag_valid_q && tag_owner_q && tag_read_q) ? bus.ram_dout_i : '0;
    bus.p0_overrun_o = overrun_q[0];
    bus.p1_overrun_o = overrun_q[1];
  end

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Bench for w0rm_mem_arbiter: table of single transactions plus hand-written
// contention, overrun and reset sequences; completions scored against a queue.
module tb_w0rm_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 10;

  logic core_clk = 1'b0;
  logic reset    = 1'b0;
  always #5 core_clk = ~core_clk;

  w0rm_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW)) bus ();

  w0rm_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RW)) dut (
    .core_clk (core_clk),
    .reset    (reset),
    .bus      (bus)
  );

  // Synchronous-read RAM model: data appears the cycle after the enable.
  logic [DW-1:0] mem [1 << RW];
  always @(posedge core_clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_din_o;
      else              bus.ram_dout_i      <= mem[bus.ram_addr_o];
    end
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  typedef struct {
    logic          port;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [RW-1:0] exp_ram_addr;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion strobe must match the oldest expectation for its port.
  always @(negedge core_clk) begin
    if (!reset) begin
      if (bus.p0_valid_o) begin
        if (exp_q0.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL p0 unexpected completion: got p0_valid_o=1, want 0");
        end else check("p0 completion data", 64'(bus.p0_data_o), 64'(exp_q0.pop_front()));
      end
      if (bus.p1_valid_o) begin
        if (exp_q1.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL p1 unexpected completion: got p1_valid_o=1, want 0");
        end else check("p1 completion data", 64'(bus.p1_data_o), 64'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p0_valid_i = 1'b0; bus.p0_read_i = 1'b0; bus.p0_write_i = 1'b0;
    bus.p0_addr_i  = '0;   bus.p0_data_i = '0;
    bus.p1_valid_i = 1'b0; bus.p1_read_i = 1'b0; bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = '0;   bus.p1_data_i = '0;
  endtask

  // Strobe one request; optionally record the completion it should produce.
  task automatic drive(input logic port, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp, input logic push);
    if (!port) begin
      bus.p0_valid_i = 1'b1; bus.p0_read_i = rd; bus.p0_write_i = wr;
      bus.p0_addr_i  = a;    bus.p0_data_i = d;
      if (push) exp_q0.push_back(exp);
    end else begin
      bus.p1_valid_i = 1'b1; bus.p1_read_i = rd; bus.p1_write_i = wr;
      bus.p1_addr_i  = a;    bus.p1_data_i = d;
      if (push) exp_q1.push_back(exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " flags"}, 64'({bus.p0_busy_o, bus.p1_busy_o, bus.p0_valid_o, bus.p1_valid_o,
                                 bus.ram_en_o, bus.ram_we_o, bus.p0_overrun_o,
                                 bus.p1_overrun_o}), 64'd0);
    check({name, " ram bus"}, 64'({bus.ram_addr_o, bus.ram_din_o}), 64'd0);
    check({name, " read data"}, {bus.p0_data_o, bus.p1_data_o}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    exp_q0.delete();
    exp_q1.delete();
    tick();
    check_all_zero("reset");
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int y_hits;
    idle_inputs();
    #2;
    do_reset();

    //            port  rd    wr    addr            data            ram addr exp rdata
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 10'h004, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         10'h004, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 10'h008, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         10'h008, 32'h1234_5678};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         10'h008, 32'h1234_5678};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h0000_1024, 32'hA5A5_A5A5, 10'h009, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0027, 32'h0,         10'h009, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 10'h00C, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0,         10'h00C, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h1111_1111, 10'h000, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 10'h3FF, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         10'h3FF, 32'h0BAD_F00D};

    // Uncontended transactions: RAM enable one cycle after the strobe, completion after two.
    for (int i = 0; i < 12; i++) begin
      logic has_op;
      has_op = vecs[i].rd | vecs[i].wr;
      drive(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
            vecs[i].exp_rdata, has_op);
      tick();
      idle_inputs();
      check($sformatf("vec%0d ram_en", i), 64'(bus.ram_en_o), 64'(has_op));
      if (has_op) begin
        check($sformatf("vec%0d ram_we", i), 64'(bus.ram_we_o), 64'(vecs[i].wr));
        check($sformatf("vec%0d ram_addr", i), 64'(bus.ram_addr_o), 64'(vecs[i].exp_ram_addr));
        if (vecs[i].wr) check($sformatf("vec%0d ram_din", i), 64'(bus.ram_din_o),
                              64'(vecs[i].data));
      end
      tick();
      check($sformatf("vec%0d valid_o {p1,p0}", i), 64'({bus.p1_valid_o, bus.p0_valid_o}),
            has_op ? (vecs[i].port ? 64'd2 : 64'd1) : 64'd0);
      tick();
      check($sformatf("vec%0d completions drained", i), 64'(exp_q0.size() + exp_q1.size()),
            64'd0);
    end
    check("no-op strobe leaves overruns clear",
          64'({bus.p1_overrun_o, bus.p0_overrun_o}), 64'd0);

    // Simultaneous strobes after reset: p0 first, then p1.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h1, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h2, 32'h0, 1'b1);
    tick();
    idle_inputs();
    check("tie: first grant addr", 64'(bus.ram_addr_o), 64'h040);
    check("tie: busy {p1,p0}", 64'({bus.p1_busy_o, bus.p0_busy_o}), 64'd2);
    tick();
    check("tie: second grant addr", 64'(bus.ram_addr_o), 64'h080);
    check("tie: first completion {p1,p0}", 64'({bus.p1_valid_o, bus.p0_valid_o}), 64'd1);
    tick();
    check("tie: second completion {p1,p0}", 64'({bus.p1_valid_o, bus.p0_valid_o}), 64'd2);
    check("tie: ram idle after", 64'(bus.ram_en_o), 64'd0);
    tick();

    // Both requesters strobe whenever free: grants alternate with no idle RAM cycle.
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc >= 1) begin
        check($sformatf("rr cyc%0d ram_en", cyc), 64'(bus.ram_en_o), 64'd1);
        check($sformatf("rr cyc%0d owner", cyc), 64'(bus.ram_addr_o[7:6]),
              (cyc % 2 == 1) ? 64'd1 : 64'd2);
      end
      idle_inputs();
      if (cyc < 8) begin
        if (!bus.p0_busy_o) drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * cyc), 32'(cyc), 32'h0, 1'b1);
        if (!bus.p1_busy_o) drive(1'b1, 1'b0, 1'b1, 32'h200 + 32'(4 * cyc), 32'(cyc), 32'h0, 1'b1);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("rr: completions drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    // p1 strobes twice back to back while p0 holds the RAM: second strobe is dropped.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h30, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h304, 32'h31, 32'h0, 1'b1);
    tick();
    idle_inputs();
    check("ovr: p1 busy while p0 granted", 64'(bus.p1_busy_o), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h308, 32'h32, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h30C, 32'h33, 32'h0, 1'b0);
    tick();
    idle_inputs();
    check("ovr: overrun {p1,p0}", 64'({bus.p1_overrun_o, bus.p0_overrun_o}), 64'd2);
    check("ovr: first p1 request granted", 64'({bus.ram_addr_o, bus.ram_din_o}),
          64'({10'h0C1, 32'h31}));
    y_hits = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.ram_en_o && bus.ram_addr_o == 10'h0C3) y_hits++;
      tick();
    end
    check("ovr: dropped request never on RAM", 64'(y_hits), 64'd0);
    check("ovr: overrun sticky", 64'(bus.p1_overrun_o), 64'd1);
    check("ovr: completions drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    // Reset asserted in the cycle a read is granted.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'h500, 32'h55, 32'h0, 1'b1);
    tick();
    idle_inputs();
    check("rst-mid: read granted before reset", 64'({bus.ram_en_o, bus.ram_we_o}), 64'd2);
    #2;
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check_all_zero("rst-mid during reset");
    tick();
    check("rst-mid: no completion", 64'({bus.p1_valid_o, bus.p0_valid_o}), 64'd0);
    reset = 1'b0;
    #1;
    check("rst-mid: slots empty, busy {p1,p0}", 64'({bus.p1_busy_o, bus.p0_busy_o}), 64'd0);
    tick();
    check("rst-mid: still no completion", 64'({bus.p1_valid_o, bus.p0_valid_o}), 64'd0);
    check("rst-mid: ram idle", 64'(bus.ram_en_o), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/w0rm_mem_arbiter.md
W0RM_MEM_ARBITER -- requirements
Module: w0rm_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data words and the RAM data buses.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of the requester byte addresses.
REQ-003 Parameter RAM_ADDR_WIDTH, default 10, SHALL set the width of the RAM word address.
REQ-004 core_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 pN_addr_i  in  ADDR_WIDTH  SHALL be the requester N byte address, N in {0,1} (0 = core data port, 1 = auxiliary master).
REQ-007 pN_data_i  in  DATA_WIDTH  SHALL be the requester N write data.
REQ-008 pN_read_i / pN_write_i  in  1 each  SHALL select read / write for requester N.
REQ-009 pN_valid_i  in  1  SHALL be a single-cycle request strobe from requester N.
REQ-010 pN_busy_o  out  1  SHALL indicate that requester N cannot present a new request this cycle.
REQ-011 pN_data_o  out  DATA_WIDTH  SHALL carry read data to requester N.
REQ-012 pN_valid_o  out  1  SHALL be a single-cycle completion strobe to requester N.
REQ-013 pN_overrun_o  out  1  SHALL be a sticky flag: requester N strobed while busy.
REQ-014 ram_en_o  out  1  SHALL be the RAM port enable.
REQ-015 ram_we_o  out  1  SHALL be the RAM port write enable.
REQ-016 ram_addr_o  out  RAM_ADDR_WIDTH  SHALL be the RAM word address.
REQ-017 ram_din_o  out  DATA_WIDTH  SHALL be the RAM write data.
REQ-018 ram_dout_i  in  DATA_WIDTH  SHALL be the RAM read data, valid one cycle after the enable cycle.

Function
REQ-019 Each requester SHALL own one pending slot holding addr, data and op (write/read).
REQ-020 A request SHALL be accepted when pN_valid_i=1, (pN_read_i|pN_write_i)=1 and pN_busy_o=0.
REQ-021 When both pN_read_i and pN_write_i are 1, the request SHALL be treated as a write.
REQ-022 When pN_valid_i=1 with both pN_read_i=0 and pN_write_i=0, the request SHALL be ignored, with no flag set.
REQ-023 pN_busy_o SHALL be combinational: slot N full and slot N not granted this cycle.
REQ-024 When slot N is granted in cycle I, a request strobed by requester N in cycle I SHALL refill the slot.
REQ-025 pN_valid_i=1 while pN_busy_o=1 SHALL drop the request and set pN_overrun_o; the existing slot contents SHALL be unchanged.
REQ-026 Each cycle, at most one full slot SHALL be granted; the grant and the RAM drive SHALL be combinational from the slot state.
REQ-027 Arbitration SHALL be round-robin: when both slots are full, the slot not granted last SHALL win.
REQ-028 The last-grant pointer SHALL update only on a grant.
REQ-029 A lone full slot SHALL always win, regardless of the pointer.
REQ-030 On a grant: ram_en_o=1, ram_we_o=op, ram_addr_o=addr[RAM_ADDR_WIDTH+1:2], ram_din_o=slot data; the slot SHALL clear at the next edge.
REQ-031 With no grant: ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_din_o=0.
REQ-032 A completion tag (valid, owner) SHALL be registered at each grant.
REQ-033 In the cycle after a grant, pN_valid_o SHALL be 1 for the owner only, for reads and writes alike.
REQ-034 pN_data_o SHALL equal ram_dout_i during a read completion and 0 otherwise.
REQ-035 Uncontended latency SHALL be: strobe in cycle N, RAM enable in N+1, pN_valid_o in N+2.
REQ-036 Throughput SHALL be one RAM access per cycle while any slot is full.
REQ-037 Address bits above RAM_ADDR_WIDTH+1 and bits [1:0] SHALL be ignored, wrapping the address modulo the RAM size.

Reset
REQ-038 Asserting reset SHALL immediately clear both slots, the completion tag and both overrun flags, and set the last-grant pointer to 1, so that p0 wins the first tie.
REQ-039 During reset, all outputs SHALL be 0.
REQ-040 After a reset mid-operation, no pN_valid_o SHALL be asserted for any access issued before reset.

Verification
REQ-041 p0 write 0xDEADBEEF to addr 0x10 in cycle 0 -> ram_en_o=1, ram_we_o=1, ram_addr_o=4 in cycle 1; p0_valid_o=1 in cycle 2.
REQ-042 p0 read of addr 0x10 after the write -> p0_valid_o=1 with p0_data_o=0xDEADBEEF two cycles after the strobe; p1_valid_o stays 0.
REQ-043 p0 and p1 strobe in the same cycle right after reset -> p0 is granted in the next cycle, p1 one cycle later; completions follow in the same order.
REQ-044 Both requesters strobing every cycle the slot is free -> grants alternate p0,p1,p0,p1; zero idle RAM cycles.
REQ-045 p1 strobes twice in consecutive cycles while p0 holds the RAM -> p1_overrun_o=1; the first p1 request completes; the second never reaches the RAM.
REQ-046 Reset asserted in the cycle a read is granted -> no pN_valid_o in the following cycle; both slots are empty; p0_busy_o=p1_busy_o=0.
